ldpc_frame_ctrl: RTL and testbench
==================================

# ldpc_frame_ctrl

Frame-level sequencer in front of the `ldpc_core` decoder array. It accepts one codeword of channel LLRs as a stream of valid/ready beats and assembles them into the flat LLR bus the core needs. It then holds the core in reset, runs it until it reports termination or a controller-side timeout expires, and presents the hard-decision word with status on a valid/ready output port. One frame is in flight at a time; the LLR buffer stays frozen while the core decodes.

## Interface
- `data_w`, 5, LLR width (matches core)
- `R`, 24, block columns of the parity-check matrix (matches core)
- `D`, 96, circulant size (matches core)
- `BEAT`, 96, LLRs per input beat; R*D must be a multiple of BEAT
- `TMO`, 80, cycles allowed in RUN before forced abort
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous and active-high
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  controller accepts a beat
- `in_data`  in  BEAT*data_w  LLR beat; LLR 0 in the LSBs
- `abort`  in  1  synchronous discard of the current frame
- `core_l`  out  R*D*data_w  assembled LLR bus to the core
- `core_rst`  out  1  core synchronous reset
- `core_en`  out  1  core iteration enable
- `core_term`  in  1  core termination flag
- `core_err`  in  1  core parity-fail flag
- `core_res`  in  R*D  core hard decisions
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts the result
- `out_data`  out  R*D  latched hard decisions
- `out_err`  out  1  parity not satisfied, or timeout
- `out_tmo`  out  1  frame ended by timeout
- `frames`  out  16  completed-frame counter, wraps at 65535->0

## Operation
- NB = R*D/BEAT beats per frame (24 at defaults). Beat index `bidx`, width log2(NB)+1. Cycle counter `cyc`, width log2(TMO)+1.
- States are LOAD, RUN and DONE. Reset enters LOAD with `bidx`=0.
- The core-control outputs decode directly from the state register: `core_rst`=(state==LOAD), `core_en`=(state==RUN), `in_ready`=(state==LOAD), `out_valid`=(state==DONE).
- **LOAD**
  - Each cycle with `in_valid`&`in_ready`, write `in_data` to `core_l[bidx*BEAT*data_w +: BEAT*data_w]` and increment `bidx`.
  - On the accept of beat NB-1: clear `bidx` and `cyc`, then go to RUN.
  - Gaps in `in_valid` stall the load without losing data.
- **RUN**
  - `cyc` increments every cycle. `core_l` is never written in this state.
  - If `core_term`=1: latch `out_data`=`core_res`, `out_err`=`core_err`, `out_tmo`=0; go to DONE.
  - Else if `cyc`==TMO-1: latch `out_data`=`core_res`, `out_err`=1, `out_tmo`=1; go to DONE.
  - If both conditions hold in the same cycle, the term branch wins.
- **DONE**
  - The core stays out of reset with `en` low, so its outputs hold.
  - On `out_valid`&`out_ready`: increment `frames` and go to LOAD.
- **abort** (highest priority in every state): go to LOAD, clear `bidx` and `cyc`. `out_data`, `out_err` and `out_tmo` keep their last values, and `frames` is not incremented. A beat presented in the same cycle as `abort` is not written.

## Timing
- Reset values: state=LOAD, `bidx`=0, `cyc`=0, `core_l`=0, `out_data`=0, `out_err`=0, `out_tmo`=0, `frames`=0. This gives `in_ready`=1, `core_rst`=1, `core_en`=0 and `out_valid`=0.
- `core_rst` is high for at least one cycle (the final accept cycle) before RUN. The core's term register is therefore 0 on the first RUN cycle.
- `core_term` is registered in the core. The controller reacts at the next edge, so `core_en` drops one cycle after `core_term` rises.
- Fastest RUN duration is 2 cycles: the core terminates on its first enabled edge.
- A timeout frame occupies exactly TMO RUN cycles.
- Output handshake:
  - `out_valid` rises the cycle after the RUN exit.
  - An `out_ready` that is already high completes the transfer in that first DONE cycle.
  - `in_ready` rises the cycle after the transfer completes.
- Throughput per frame is NB + RUN cycles + 1 or more DONE cycles. Loading does not overlap decoding.
- Asynchronous `rst` mid-frame returns every register to its reset value immediately, independent of `clk`.

## Test plan
- **Full frame, clean core model:** 24 back-to-back beats with beat k filled with LLR value k; model asserts `core_term`=1 with `core_err`=0 after 5 enabled cycles. Expect `core_l` to hold beat k at slice k, `core_en` high 6 cycles, `out_valid`=1 with `out_data`=model `core_res`, `out_err`=0, `out_tmo`=0; `frames`=1 after `out_ready`.
- **Timeout:** model never asserts `core_term`. Expect exactly 80 RUN cycles, then `out_err`=1, `out_tmo`=1.
- **Term and timeout coincide:** `core_term` rises in RUN cycle 79. Expect `out_tmo`=0, `out_err`=`core_err`.
- **Back-pressure and input gaps:** `in_valid` toggled 1010…, then `out_ready` held low 10 cycles in DONE. Expect the correct beat order, `out_valid` and `out_data` held stable, `in_ready`=0 throughout DONE, and `frames` incremented once.
- **Abort:** `abort` pulsed after beat 12, then a full frame loaded. Expect `bidx` restarting at 0 and a correct frame; `abort` in RUN returns to LOAD with `frames` unchanged.
- **Async reset in RUN:** assert `rst` between clock edges. Expect all outputs at their reset values before the next edge.

Source files
------------

// File: rtl/ldpc_frame_ctrl.sv
// Frame sequencer for ldpc_core. It loads one codeword of LLR beats and runs the core
// until termination or timeout, then presents the hard decisions on a valid/ready port.
module ldpc_frame_ctrl #(
  parameter int data_w = 5,
  parameter int R      = 24,
  parameter int D      = 96,
  parameter int BEAT   = 96,
  parameter int TMO    = 80
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BEAT*data_w-1:0]  in_data,
  input  logic                    abort,
  output logic [R*D*data_w-1:0]   core_l,
  output logic                    core_rst,
  output logic                    core_en,
  input  logic                    core_term,
  input  logic                    core_err,
  input  logic [R*D-1:0]          core_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [R*D-1:0]          out_data,
  output logic                    out_err,
  output logic                    out_tmo,
  output logic [15:0]             frames
);

  localparam int NB     = (R * D) / BEAT;
  localparam int BW     = BEAT * data_w;
  localparam int BIDX_W = $clog2(NB) + 1;
  localparam int CYC_W  = $clog2(TMO) + 1;
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(NB - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TMO - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [BIDX_W-1:0]   bidx_r;
  logic [CYC_W-1:0]    cyc_r;
  logic [R*D*data_w-1:0] core_l_r;
  logic [R*D-1:0]      out_data_r;
  logic                out_err_r;
  logic                out_tmo_r;
  logic [15:0]         frames_r;
  logic                accept_s;
  logic                last_beat_s;
  logic                tmo_hit_s;
  logic                xfer_s;

  // Next-state logic; abort overrides every state.
  always_comb begin
    state_s     = state_r;
    accept_s    = (state_r == LOAD) && in_valid && !abort;
    last_beat_s = accept_s && (bidx_r == BIDX_LAST);
    tmo_hit_s   = (cyc_r == CYC_LAST);
    xfer_s      = (state_r == DONE) && out_ready && !abort;
    if (abort) begin
      state_s = LOAD;
    end else begin
      case (state_r)
        LOAD:    if (last_beat_s) state_s = RUN;  else state_s = LOAD;
        RUN:     if (core_term || tmo_hit_s) state_s = DONE; else state_s = RUN;
        DONE:    if (xfer_s) state_s = LOAD; else state_s = DONE;
        default: state_s = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= LOAD;
    else     state_r <= state_s;
  end

  // Beat assembly, cycle budget, result latch and frame count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bidx_r     <= '0;
      cyc_r      <= '0;
      core_l_r   <= '0;
      out_data_r <= '0;
      out_err_r  <= 1'b0;
      out_tmo_r  <= 1'b0;
      frames_r   <= 16'd0;
    end else if (abort) begin
      bidx_r <= '0;
      cyc_r  <= '0;
    end else begin
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            for (int k = 0; k < NB; k++) begin
              if (bidx_r == BIDX_W'(k)) core_l_r[k*BW +: BW] <= in_data;
            end
            if (last_beat_s) begin
              bidx_r <= '0;
              cyc_r  <= '0;
            end else begin
              bidx_r <= bidx_r + BIDX_W'(1);
            end
          end
        end
        RUN: begin
          cyc_r <= cyc_r + CYC_W'(1);
          // Termination takes precedence over a coincident timeout.
          if (core_term) begin
            out_data_r <= core_res;
            out_err_r  <= core_err;
            out_tmo_r  <= 1'b0;
          end else if (tmo_hit_s) begin
            out_data_r <= core_res;
            out_err_r  <= 1'b1;
            out_tmo_r  <= 1'b1;
          end
        end
        DONE: begin
          if (xfer_s) frames_r <= frames_r + 16'd1;
        end
        default: begin
          bidx_r <= '0;
          cyc_r  <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == LOAD);
  assign core_rst  = (state_r == LOAD);
  assign core_en   = (state_r == RUN);
  assign out_valid = (state_r == DONE);
  assign core_l    = core_l_r;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;
  assign out_tmo   = out_tmo_r;
  assign frames    = frames_r;

endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// Randomized bench for ldpc_frame_ctrl: the bench plays the core and predicts each frame
// (LLR image, RUN length, status, frame count) from frame-level rules.
module tb_ldpc_frame_ctrl;
  localparam int DW   = 5;
  localparam int R    = 24;
  localparam int D    = 96;
  localparam int BEAT = 96;
  localparam int TMO  = 80;
  localparam int NB   = R * D / BEAT;
  localparam int BW   = BEAT * DW;
  localparam int LW   = R * D * DW;
  localparam int HW   = R * D;

  logic          clk = 1'b0;
  logic          rst, in_valid, abort, core_term, core_err, out_ready;
  logic [BW-1:0] in_data;
  logic [HW-1:0] core_res;
  logic          in_ready, core_rst, core_en, out_valid, out_err, out_tmo;
  logic [LW-1:0] core_l;
  logic [HW-1:0] out_data;
  logic [15:0]   frames;

  logic [LW-1:0] exp_l;
  logic [HW-1:0] exp_data;
  logic          exp_err, exp_tmo;
  logic [15:0]   exp_frames;
  int            core_cnt, term_after;
  int            n_checks = 0, n_errors = 0;

  ldpc_frame_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .abort(abort), .core_l(core_l), .core_rst(core_rst), .core_en(core_en),
    .core_term(core_term), .core_err(core_err), .core_res(core_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_tmo(out_tmo), .frames(frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
    int w;
    n_checks++;
    if (got !== want) begin
      n_errors++;
      w = 0;
      for (int i = LW/64 - 1; i >= 0; i--) if (got[i*64 +: 64] !== want[i*64 +: 64]) w = i;
      $display("FAIL %s: got %h expected %h (64-bit word %0d)", tag, got[w*64 +: 64],
               want[w*64 +: 64], w);
    end
  endtask

  // One clock; the core model registers term after term_after enabled edges.
  task automatic tick();
    logic en_q, rst_q;
    en_q  = core_en;
    rst_q = core_rst;
    @(posedge clk);
    #1;
    if (rst_q) begin
      core_cnt  = 0;
      core_term = 1'b0;
    end else if (en_q) begin
      core_cnt++;
      core_term = (term_after != 0) && (core_cnt >= term_after);
    end
  endtask

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] v;
    for (int i = 0; i < BW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [HW-1:0] rand_res();
    logic [HW-1:0] v;
    for (int i = 0; i < HW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic load_frame(input int t_after, input int gap_mode, input int nbeats, input bit fill_k);
    logic [BW-1:0] b;
    logic [DW-1:0] kv;
    core_res   = rand_res();
    core_err   = 1'($urandom_range(0, 1));
    term_after = t_after;
    for (int k = 0; k < nbeats; k++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        in_data  = rand_beat();
        tick();
      end
      kv = k[DW-1:0];
      b  = fill_k ? {BEAT{kv}} : rand_beat();
      chk("in_ready_load", LW'(in_ready), LW'(1'b1));
      in_valid = 1'b1;
      in_data  = b;
      tick();
      exp_l[k*BW +: BW] = b;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input int hold);
    int run_cycles, exp_run;
    bit term_wins;
    chk("run_entry_en", LW'({core_en, core_rst, in_ready}), LW'(3'b100));
    chk("core_l_loaded", core_l, exp_l);
    run_cycles = 0;
    while (core_en && run_cycles < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rand_beat();
      tick();
      run_cycles++;
    end
    in_valid  = 1'b0;
    term_wins = (term_after >= 1) && (term_after <= TMO - 1);
    exp_run   = term_wins ? term_after + 1 : TMO;
    exp_tmo   = !term_wins;
    exp_err   = exp_tmo ? 1'b1 : core_err;
    exp_data  = core_res;
    chk("run_len", LW'(run_cycles), LW'(exp_run));
    chk("core_l_frozen", core_l, exp_l);
    chk("done_ctrl", LW'({out_valid, in_ready, core_en, core_rst}), LW'(4'b1000));
    chk("out_data", LW'(out_data), LW'(exp_data));
    chk("out_err", LW'(out_err), LW'(exp_err));
    chk("out_tmo", LW'(out_tmo), LW'(exp_tmo));
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", LW'({out_valid, in_ready}), LW'(2'b10));
      chk("hold_data", LW'(out_data), LW'(exp_data));
    end
    out_ready = 1'b1;
    tick();
    out_ready  = 1'b0;
    exp_frames = exp_frames + 16'd1;
    chk("frames", LW'(frames), LW'(exp_frames));
    chk("back_to_load", LW'({out_valid, in_ready, core_rst}), LW'(3'b011));
  endtask

  task automatic chk_held_result(input string tag);
    chk(tag, LW'({out_data, out_err, out_tmo, frames}), LW'({exp_data, exp_err, exp_tmo, exp_frames}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    core_term = 1'b0; core_err = 1'b0; core_res = '0; in_data = '0;
    core_cnt = 0; term_after = 0;
    exp_l = '0; exp_data = '0; exp_err = 1'b0; exp_tmo = 1'b0; exp_frames = 16'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_ctrl", LW'({in_ready, core_rst, core_en, out_valid}), LW'(4'b1100));
    chk("reset_core_l", core_l, exp_l);
    chk_held_result("reset_result");
    rst = 1'b0;
    tick();

    // Clean frame, beat k filled with value k, term after 5 enabled edges.
    load_frame(5, 0, NB, 1'b1);
    finish_frame(0);
    // Timeout, then term coinciding with the last allowed cycle.
    load_frame(0, 0, NB, 1'b0);
    finish_frame(0);
    load_frame(TMO - 1, 0, NB, 1'b0);
    finish_frame(1);
    load_frame(TMO, 0, NB, 1'b0);
    finish_frame(0);
    // Gapped input, fastest termination, downstream back-pressure.
    load_frame(1, 1, NB, 1'b0);
    finish_frame(10);

    // Abort after beat 12 with a beat on the bus; that beat must not land.
    load_frame(3, 0, 12, 1'b0);
    in_valid = 1'b1; in_data = rand_beat(); abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_load_l", core_l, exp_l);
    chk("abort_load_ctrl", LW'({in_ready, core_rst, core_en}), LW'(3'b110));
    load_frame(4, 2, NB, 1'b0);
    finish_frame(2);

    // Abort during RUN.
    load_frame(0, 0, NB, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("run_mid_en", LW'(core_en), LW'(1'b1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_ctrl", LW'({in_ready, core_rst, core_en, out_valid}), LW'(4'b1100));
    chk_held_result("abort_run_result");
    tick();
    chk_held_result("abort_run_result2");

    for (int f = 0; f < 10; f++) begin
      load_frame($urandom_range(0, 90), 2, NB, 1'b0);
      finish_frame($urandom_range(0, 4));
    end

    // Asynchronous reset between edges while running.
    load_frame(0, 0, NB, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b1;
    #1;
    exp_l = '0; exp_data = '0; exp_err = 1'b0; exp_tmo = 1'b0; exp_frames = 16'd0;
    chk("async_rst_ctrl", LW'({in_ready, core_rst, core_en, out_valid}), LW'(4'b1100));
    chk("async_rst_l", core_l, exp_l);
    chk_held_result("async_rst_result");
    #1 rst = 1'b0;
    core_term = 1'b0; core_cnt = 0;
    tick();
    load_frame(6, 2, NB, 1'b0);
    finish_frame(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
